// File: rtl/hazard_scoreboard_pkg.sv
// Shared CPU types: the scoreboard entry layout and the forwarding-select encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_types_pkg;

  localparam int REGBITS_W = 5;
  typedef logic [REGBITS_W-1:0] regbits_t;

  // One in-flight instruction as seen by the hazard logic
  typedef struct packed {
    logic     valid;
    regbits_t dst;
    logic     wen;
    logic     load;
  } hz_entry_t;

  // Forwarding select value meaning "use the register file read"
  localparam int FWD_RF = 0;

endpackage

// File: rtl/hazard_scoreboard_hz_match.sv
// Youngest-match priority encoder of one source register against the in-flight entries.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module hz_match
  import cpu_types_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int IDX_W  = 2
) (
  input  hz_entry_t [STAGES-1:0] i_entries,
  input  regbits_t               i_src,
  input  logic                   i_used,
  output logic                   o_hit,
  output logic [IDX_W-1:0]       o_index,
  output logic                   o_is_load
);

  // Scan oldest to youngest so the youngest (lowest index) match is the last writer
  always_comb begin
    o_hit     = 1'b0;
    o_index   = '0;
    o_is_load = 1'b0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      if (i_used && i_entries[j].valid && i_entries[j].wen &&
          (i_entries[j].dst == i_src) && (i_entries[j].dst != '0)) begin
        o_hit     = 1'b1;
        o_index   = IDX_W'(j);
        o_is_load = i_entries[j].load;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: load-use stall, bubble insertion, registered forwarding selects.
// Latency: stall is combinational from id_*; ex_fwd_sel updates one advancing edge after decode.
// Backpressure: adv=0 freezes all state; optional counters enabled by HAZARD_STATS_EN.
module hazard_scoreboard
  import cpu_types_pkg::*;
#(
  parameter  int STAGES   = 3,
  parameter  int NSRC     = 2,
  parameter  int REG_W    = 5,
  parameter  int LOAD_LAT = 1,
  localparam int SEL_W    = $clog2(STAGES + 1)
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         adv,
  input  logic                         id_valid,
  input  logic [NSRC-1:0][REG_W-1:0]   id_src,
  input  logic [NSRC-1:0]              id_src_used,
  input  logic [REG_W-1:0]             id_dst,
  input  logic                         id_wen,
  input  logic                         id_load,
  input  logic                         flush,
  output logic                         stall,
  output logic [NSRC-1:0][SEL_W-1:0]   ex_fwd_sel
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  flush_cnt
`endif
);

  hz_entry_t [STAGES-1:0]       r_sb;
  logic [NSRC-1:0][SEL_W-1:0]   r_fwd;

  logic [NSRC-1:0]              w_hit;
  logic [NSRC-1:0]              w_is_load;
  logic [NSRC-1:0][SEL_W-1:0]   w_idx;
  logic [NSRC-1:0]              w_ld_hz;
  logic [NSRC-1:0][SEL_W-1:0]   w_fwd_nxt;
  logic                         w_stall;
  logic                         w_take;
  hz_entry_t                    w_new;

  for (genvar s = 0; s < NSRC; s++) begin : g_match
    hz_match #(
      .STAGES (STAGES),
      .IDX_W  (SEL_W)
    ) u_match (
      .i_entries (r_sb),
      .i_src     (regbits_t'(id_src[s])),
      .i_used    (id_src_used[s]),
      .o_hit     (w_hit[s]),
      .o_index   (w_idx[s]),
      .o_is_load (w_is_load[s])
    );
  end

  // Hazard detection, decode acceptance and next forwarding selects
  always_comb begin
    w_ld_hz   = '0;
    w_fwd_nxt = '0;
    for (int s = 0; s < NSRC; s++) begin
      w_ld_hz[s] = w_hit[s] & w_is_load[s] & (int'(w_idx[s]) < LOAD_LAT);
    end
    // flush overrides the stall: the wrong-path instruction is dropped anyway
    w_stall = id_valid & ~flush & (|w_ld_hz);
    w_take  = id_valid & ~w_stall & ~flush;
    w_new   = '0;
    if (w_take) begin
      w_new = '{valid: 1'b1, dst: regbits_t'(id_dst), wen: id_wen, load: id_load};
    end
    for (int s = 0; s < NSRC; s++) begin
      // Matches in WB are served by write-before-read in the register file
      if (w_take && w_hit[s] && (int'(w_idx[s]) <= STAGES - 2)) begin
        w_fwd_nxt[s] = w_idx[s] + 1'b1;
      end else begin
        w_fwd_nxt[s] = SEL_W'(FWD_RF);
      end
    end
  end

  // Scoreboard shift and forwarding-select register, frozen when the pipe does not advance
  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_sb  <= '0;
      r_fwd <= '0;
    end else if (adv) begin
      for (int j = STAGES - 1; j > 0; j--) begin
        r_sb[j] <= r_sb[j-1];
      end
      r_sb[0] <= w_new;
      r_fwd   <= w_fwd_nxt;
    end
  end

  assign stall      = w_stall;
  assign ex_fwd_sel = r_fwd;

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating event counters for advancing stall and flush cycles
  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (adv && w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (adv && flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic.
// Reference model tracks in-flight instructions as plain arrays and applies the hazard rules.
// Counter checks are compiled in only when HAZARD_STATS_EN is defined.
module tb_hazard_scoreboard;
  import cpu_types_pkg::*;

  localparam int STAGES   = 3;
  localparam int NSRC     = 2;
  localparam int REG_W    = 5;
  localparam int LOAD_LAT = 1;
  localparam int SEL_W    = $clog2(STAGES + 1);

  logic                        CLK = 1'b0;
  logic                        nRST;
  logic                        adv;
  logic                        id_valid;
  logic [NSRC-1:0][REG_W-1:0]  id_src;
  logic [NSRC-1:0]             id_src_used;
  logic [REG_W-1:0]            id_dst;
  logic                        id_wen;
  logic                        id_load;
  logic                        flush;
  logic                        stall;
  logic [NSRC-1:0][SEL_W-1:0]  ex_fwd_sel;
`ifdef HAZARD_STATS_EN
  logic [31:0]                 stall_cnt;
  logic [31:0]                 flush_cnt;
`endif

  always #5 CLK = ~CLK;

  hazard_scoreboard #(
    .STAGES   (STAGES),
    .NSRC     (NSRC),
    .REG_W    (REG_W),
    .LOAD_LAT (LOAD_LAT)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .adv         (adv),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_dst      (id_dst),
    .id_wen      (id_wen),
    .id_load     (id_load),
    .flush       (flush),
    .stall       (stall),
    .ex_fwd_sel  (ex_fwd_sel)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: what instruction sits in EX/MEM/WB, and the selects last handed to EX
  bit  m_v   [STAGES];
  int  m_dst [STAGES];
  bit  m_wen [STAGES];
  bit  m_ld  [STAGES];
  int  m_fwd [NSRC];
  longint m_scnt;
  longint m_fcnt;

  // Index of the youngest in-flight producer of source s, or -1
  function automatic int youngest(input int s);
    if (!id_src_used[s]) return -1;
    for (int j = 0; j < STAGES; j++) begin
      if (m_v[j] && m_wen[j] && m_dst[j] != 0 && m_dst[j] == int'(id_src[s])) return j;
    end
    return -1;
  endfunction

  function automatic bit m_stall();
    if (!id_valid || flush) return 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      int j;
      j = youngest(s);
      if (j >= 0 && m_ld[j] && j < LOAD_LAT) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock edge; the model takes the same edge using the inputs present before it
  task automatic tick();
    bit st, take;
    int nf [NSRC];
    st   = m_stall();
    take = id_valid && !st && !flush;
    for (int s = 0; s < NSRC; s++) begin
      int j;
      j = youngest(s);
      nf[s] = (take && j >= 0 && j + 1 < STAGES) ? j + 1 : 0;
    end
    @(posedge CLK);
    #1;
    if (nRST) begin
      for (int j = 0; j < STAGES; j++) begin
        m_v[j] = 0; m_dst[j] = 0; m_wen[j] = 0; m_ld[j] = 0;
      end
      for (int s = 0; s < NSRC; s++) m_fwd[s] = 0;
      m_scnt = 0;
      m_fcnt = 0;
    end else if (adv) begin
      if (st && m_scnt < 64'hFFFF_FFFF) m_scnt++;
      if (flush && m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
      for (int j = STAGES - 1; j > 0; j--) begin
        m_v[j] = m_v[j-1]; m_dst[j] = m_dst[j-1]; m_wen[j] = m_wen[j-1]; m_ld[j] = m_ld[j-1];
      end
      m_v[0]   = take;
      m_dst[0] = take ? int'(id_dst) : 0;
      m_wen[0] = take ? id_wen : 1'b0;
      m_ld[0]  = take ? id_load : 1'b0;
      for (int s = 0; s < NSRC; s++) m_fwd[s] = nf[s];
    end
  endtask

  task automatic drive(input bit v, input int s0, input bit u0, input int s1, input bit u1,
                       input int d, input bit w, input bit ld, input bit fl, input bit a);
    id_valid       = v;
    id_src[0]      = REG_W'(s0);
    id_src_used[0] = u0;
    id_src[1]      = REG_W'(s1);
    id_src_used[1] = u1;
    id_dst         = REG_W'(d);
    id_wen         = w;
    id_load        = ld;
    flush          = fl;
    adv            = a;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
    end
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++;
    if (ex_fwd_sel !== '0) begin failures++; $display("FAIL reset_fwd got=%h exp=0", ex_fwd_sel); end
    nRST = 1'b0;
    // lw $3 in flight, then reset while it is valid
    drive(1, 1, 1, 0, 0, 3, 1, 1, 0, 1);
    tick();
    nRST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    nRST = 1'b0;
    drive(1, 3, 1, 3, 1, 8, 1, 0, 0, 1);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_mid_stall got=%b exp=0", stall); end
    tick();
    checks++;
    if (ex_fwd_sel !== '0) begin failures++; $display("FAIL reset_mid_fwd got=%h exp=0", ex_fwd_sel); end
  endtask

  task automatic test_alu_chain();
    idle(3);
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 1);       // add $3,$1,$2
    tick();
    drive(1, 3, 1, 5, 1, 4, 1, 0, 0, 1);       // sub $4,$3,$5
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", stall); end
    tick();
    checks++;
    if (ex_fwd_sel[0] !== 2'd1 || ex_fwd_sel[1] !== 2'd0) begin
      failures++; $display("FAIL alu_fwd1 got=%0d,%0d exp=1,0", ex_fwd_sel[0], ex_fwd_sel[1]);
    end
    drive(1, 3, 1, 6, 1, 7, 1, 0, 0, 1);       // or $7,$3,$6
    tick();
    checks++;
    if (ex_fwd_sel[0] !== 2'd2 || ex_fwd_sel[1] !== 2'd0) begin
      failures++; $display("FAIL alu_fwd2 got=%0d,%0d exp=2,0", ex_fwd_sel[0], ex_fwd_sel[1]);
    end
  endtask

  task automatic test_load_use();
    idle(3);
    drive(1, 1, 1, 0, 0, 2, 1, 1, 0, 1);       // lw $2
    tick();
    drive(1, 2, 1, 2, 1, 6, 1, 0, 0, 1);       // add $6,$2,$2
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall); end
    tick();
    checks++;
    if (ex_fwd_sel !== '0) begin failures++; $display("FAIL lu_bubble got=%h exp=0", ex_fwd_sel); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL lu_release got=%b exp=0", stall); end
    tick();
    checks++;
    if (ex_fwd_sel[0] !== 2'd2 || ex_fwd_sel[1] !== 2'd2) begin
      failures++; $display("FAIL lu_fwd got=%0d,%0d exp=2,2", ex_fwd_sel[0], ex_fwd_sel[1]);
    end
  endtask

  task automatic test_flush_stall();
    idle(3);
    drive(1, 1, 1, 0, 0, 2, 1, 1, 0, 1);       // lw $2
    tick();
    drive(1, 2, 1, 2, 1, 6, 1, 0, 1, 1);       // add $6,$2,$2 on the wrong path
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL fl_stall got=%b exp=0", stall); end
    tick();
    checks++;
    if (ex_fwd_sel !== '0) begin failures++; $display("FAIL fl_fwd got=%h exp=0", ex_fwd_sel); end
    // The flushed add must not be visible as a producer of $6
    drive(1, 6, 1, 2, 1, 9, 1, 0, 0, 1);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL fl_after_stall got=%b exp=0", stall); end
    tick();
    checks++;
    if (ex_fwd_sel[0] !== 2'd0 || ex_fwd_sel[1] !== 2'd2) begin
      failures++; $display("FAIL fl_bubble got=%0d,%0d exp=0,2", ex_fwd_sel[0], ex_fwd_sel[1]);
    end
  endtask

  task automatic test_adv_hold();
    idle(3);
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0, 1);       // lw $5
    tick();
    drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);       // user of $5, pipe frozen
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall !== 1'b1) begin failures++; $display("FAIL hold_stall%0d got=%b exp=1", i, stall); end
      tick();
      checks++;
      if (int'(ex_fwd_sel[0]) != m_fwd[0] || int'(ex_fwd_sel[1]) != m_fwd[1] || m_fwd[0] != 0) begin
        failures++; $display("FAIL hold_fwd%0d got=%0d,%0d exp=0,0", i, ex_fwd_sel[0], ex_fwd_sel[1]);
      end
    end
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL hold_stall_end got=%b exp=1", stall); end
    drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 1);
    tick();
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL hold_release got=%b exp=0", stall); end
    tick();
    checks++;
    if (ex_fwd_sel[0] !== 2'd2) begin
      failures++; $display("FAIL hold_fwd_after got=%0d exp=2", ex_fwd_sel[0]);
    end
  endtask

  task automatic test_zero_reg();
    idle(3);
    drive(1, 1, 1, 0, 0, 0, 1, 0, 0, 1);       // add $0
    tick();
    drive(1, 0, 1, 0, 1, 4, 1, 0, 0, 1);       // reader of $0
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL zero_stall got=%b exp=0", stall); end
    tick();
    checks++;
    if (ex_fwd_sel !== '0) begin failures++; $display("FAIL zero_fwd got=%h exp=0", ex_fwd_sel); end
    drive(1, 1, 1, 0, 0, 0, 1, 1, 0, 1);       // lw $0
    tick();
    drive(1, 0, 1, 0, 1, 4, 1, 0, 0, 1);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL zero_load_stall got=%b exp=0", stall); end
    tick();
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    nRST = 1'b1;
    idle(1);
    nRST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 0, 0, 7, 1, 1, 0, 1);     // lw $7
      tick();
      drive(1, 7, 1, 0, 0, 8, 1, 0, 0, 1);     // stalled user, advancing
      tick();
      idle(1);
    end
    checks++;
    if (stall_cnt !== 32'd5) begin failures++; $display("FAIL stats_stall got=%0d exp=5", stall_cnt); end
    checks++;
    if (flush_cnt !== 32'd0) begin failures++; $display("FAIL stats_flush got=%0d exp=0", flush_cnt); end
  endtask
`endif

  task automatic test_random();
    nRST = 1'b1;
    idle(1);
    nRST = 1'b0;
    for (int i = 0; i < 600; i++) begin
      nRST = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) < 8,
            $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) < 4,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 8);
      checks++;
      if (stall !== m_stall()) begin
        failures++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", i, stall, m_stall());
      end
      tick();
      for (int s = 0; s < NSRC; s++) begin
        checks++;
        if (int'(ex_fwd_sel[s]) != m_fwd[s]) begin
          failures++; $display("FAIL rand_fwd cyc=%0d src=%0d got=%0d exp=%0d", i, s, ex_fwd_sel[s], m_fwd[s]);
        end
      end
    end
    nRST = 1'b0;
`ifdef HAZARD_STATS_EN
    checks++;
    if (longint'(stall_cnt) != m_scnt) begin
      failures++; $display("FAIL rand_stall_cnt got=%0d exp=%0d", stall_cnt, m_scnt);
    end
    checks++;
    if (longint'(flush_cnt) != m_fcnt) begin
      failures++; $display("FAIL rand_flush_cnt got=%0d exp=%0d", flush_cnt, m_fcnt);
    end
`endif
  endtask

  initial begin
    nRST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu_chain();
    test_load_use();
    test_flush_stall();
    test_adv_hold();
    test_zero_reg();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the pipelined datapath. It records the destination register of every instruction in flight beyond decode. It raises a decode stall on load-use hazards, injects bubbles on stall and flush, and registers per-operand forwarding selects that the execute stage consumes. It sits beside the IF/ID and ID/EX latches and drives their stall/flush and the ALU operand muxes.

## Interface
Parameters:
- STAGES, 3, tracked in-flight stages after decode (entry 0 = EX, 1 = MEM, 2 = WB).
- NSRC, 2, source operands per instruction.
- REG_W, 5, register index width.
- LOAD_LAT, 1, number of youngest entries from which load data cannot yet be forwarded.

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  clock.
- nRST  in  1  synchronous, active-high reset; 1 clears all state at the CLK edge.
- adv  in  1  pipeline advance enable (ihit & ~dhit).
- id_valid  in  1  decode holds a real instruction.
- id_src  in  NSRC×REG_W  decode source registers.
- id_src_used  in  NSRC  per-source "operand read" flags.
- id_dst  in  REG_W  decode destination register.
- id_wen  in  1  decode instruction writes the register file.
- id_load  in  1  decode instruction is a load.
- flush  in  1  taken branch or jump resolved in EX; the decode instruction is wrong-path.
- stall  out  1  combinational; hold PC and IF/ID, bubble ID/EX.
- ex_fwd_sel  out  NSRC×$clog2(STAGES+1)  registered; 0 = register file, k = latch output of entry k-1.
- stall_cnt, flush_cnt  out  32 each  present only with the macro (see Configuration).

## Operation
- Scoreboard: a STAGES-deep shift register of entries {valid, dst, wen, load}.
- Match: source s matches entry j when id_src_used[s], entry j is valid, wen=1, dst == id_src[s], and dst != 0. The youngest (lowest j) match wins.
- stall = id_valid & ~flush & (∃s: youngest match of s is a load with j < LOAD_LAT).
- On a CLK edge with adv=1, entries shift j→j+1 and the oldest entry is dropped. Entry 0 is loaded with:
  - the decode instruction if id_valid & ~stall & ~flush;
  - otherwise a bubble (valid=0).
- On the same edge, ex_fwd_sel[s] is updated:
  - if the youngest match is at j ≤ STAGES-2, it takes j+1;
  - otherwise it takes 0 (WB is covered by register-file write-before-read).
  - A bubble loads all zeros.
- adv=0: all state holds, including ex_fwd_sel. stall is still evaluated combinationally.
- flush together with stall: flush wins. stall=0 and a bubble is inserted.
- Register 0 never matches, regardless of wen.

## Timing
- Reset: all entries are invalid, ex_fwd_sel=0, stall=0, and counters are 0. Reset has priority over adv.
- Reset asserted mid-operation clears the scoreboard at that edge. No stall is emitted in the following cycle.
- stall has zero latency from the id_* inputs. ex_fwd_sel becomes valid one edge after decode advances and is aligned with the instruction entering EX.
- A load-use stall lasts exactly LOAD_LAT advancing cycles with the default LOAD_LAT=1. Cycles with adv=0 extend it.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_cnt increments on each edge where adv & stall.
  - flush_cnt increments on each edge where adv & flush.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- HAZARD_STATS_EN undefined: both ports and both counters are absent, and the logic is otherwise identical.

## Structure
- In the shared package cpu_types_pkg: the scoreboard entry struct hz_entry_t {valid, dst (regbits_t), wen, load} and the constant FWD_RF = 0.
- One sub-module, hz_match: combinational youngest-match priority encoder. It is instantiated NSRC times and returns {hit, index, is_load}.

## Test plan
- Reset with nRST=1 while entries are valid. Required: stall=0 and ex_fwd_sel=0 on the next cycle. An instruction reading $3 then advances with ex_fwd_sel=0.
- ALU chain: `add $3` followed by `sub $4,$3,$5`, adv=1. Required: no stall, and ex_fwd_sel[0]=1 on the edge where sub enters EX. One instruction later, a reader of $3 gets ex_fwd_sel=2.
- Load-use: `lw $2` followed by `add $6,$2,$2`. Required:
  - stall=1 for one cycle and a bubble in entry 0;
  - the add then enters with ex_fwd_sel={2,2}.
- Flush while stalled: lw/use hazard with flush=1 in the same cycle. Required: stall=0, entry 0 becomes a bubble, and ex_fwd_sel=0.
- adv=0 for 3 cycles mid-hazard. Required: stall stays 1 and all state is held. The stall releases after the first adv=1 edge.
- $0 writer (`add $0`) followed by a reader of $0. Required: no match and ex_fwd_sel=0. With HAZARD_STATS_EN, five stalled advancing cycles read stall_cnt=5.
